// File: rtl/mem_arb_pkg.sv
// Shared widths and FSM state type for the two-master memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ARB_ADDR_WIDTH  = 64;
    localparam int unsigned ARB_DATA_WIDTH  = 64;
    localparam int unsigned ARB_BURST_BEATS = 2;
    localparam int unsigned MEM_DATA_WIDTH  = ARB_DATA_WIDTH * 2;
    localparam int unsigned MEM_MASK_WIDTH  = MEM_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_RD = 2'd1,
        GRANT_WR = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker: a lone requester wins, a tie goes to ptr.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       grant
);

    always_comb begin
        unique case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ptr;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 128-bit memory port between the I-cache (m0) and D-cache (m1) CMUs, burst-locked.
// Define ARB_PERF_EN to add per-master burst and stall counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ARB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = ARB_DATA_WIDTH,
    parameter int unsigned BURST_BEATS = ARB_BURST_BEATS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        m0_ren,
    input  logic [ADDR_WIDTH-1:0]       m0_raddr,
    output logic [DATA_WIDTH*2-1:0]     m0_rdata,
    output logic                        m0_rvalid,
    input  logic                        m0_wen,
    input  logic [ADDR_WIDTH-1:0]       m0_waddr,
    input  logic [DATA_WIDTH*2-1:0]     m0_wdata,
    input  logic [DATA_WIDTH*2/8-1:0]   m0_wmask,
    output logic                        m0_wvalid,
    input  logic                        m1_ren,
    input  logic [ADDR_WIDTH-1:0]       m1_raddr,
    output logic [DATA_WIDTH*2-1:0]     m1_rdata,
    output logic                        m1_rvalid,
    input  logic                        m1_wen,
    input  logic [ADDR_WIDTH-1:0]       m1_waddr,
    input  logic [DATA_WIDTH*2-1:0]     m1_wdata,
    input  logic [DATA_WIDTH*2/8-1:0]   m1_wmask,
    output logic                        m1_wvalid,
    output logic                        mem_ren,
    output logic [ADDR_WIDTH-1:0]       mem_raddr,
    input  logic [DATA_WIDTH*2-1:0]     mem_rdata,
    input  logic                        mem_rvalid,
    output logic                        mem_wen,
    output logic [ADDR_WIDTH-1:0]       mem_waddr,
    output logic [DATA_WIDTH*2-1:0]     mem_wdata,
    output logic [DATA_WIDTH*2/8-1:0]   mem_wmask,
    input  logic                        mem_wvalid,
    output logic                        owner
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]                 perf_grant0,
    output logic [31:0]                 perf_grant1,
    output logic [31:0]                 perf_stall0,
    output logic [31:0]                 perf_stall1
`endif
);

    localparam int unsigned CW = $clog2(BURST_BEATS) + 1;

    arb_state_t    state;
    logic [CW-1:0] beat_cnt;
    logic          rr_ptr;
    logic [1:0]    req;
    logic          win;
    logic          win_wen;
    logic          beat_fire;
    logic          burst_done;

    assign req     = {m1_ren | m1_wen, m0_ren | m0_wen};
    assign win_wen = win ? m1_wen : m0_wen;

    arb_rr2 u_rr (
        .req  (req),
        .ptr  (rr_ptr),
        .grant(win)
    );

    // Only valids in the granted direction advance the burst.
    assign beat_fire  = ((state == GRANT_RD) && mem_rvalid) ||
                        ((state == GRANT_WR) && mem_wvalid);
    assign burst_done = beat_fire && (beat_cnt == CW'(BURST_BEATS - 1));

    assign m0_rdata = mem_rdata;
    assign m1_rdata = mem_rdata;

    always_comb begin
        mem_ren   = 1'b0;
        mem_raddr = '0;
        mem_wen   = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (state == GRANT_RD) begin
            mem_ren   = owner ? m1_ren   : m0_ren;
            mem_raddr = owner ? m1_raddr : m0_raddr;
        end
        if (state == GRANT_WR) begin
            mem_wen   = owner ? m1_wen   : m0_wen;
            mem_waddr = owner ? m1_waddr : m0_waddr;
            mem_wdata = owner ? m1_wdata : m0_wdata;
            mem_wmask = owner ? m1_wmask : m0_wmask;
        end
    end

    assign m0_rvalid = mem_rvalid && (state == GRANT_RD) && !owner;
    assign m1_rvalid = mem_rvalid && (state == GRANT_RD) &&  owner;
    assign m0_wvalid = mem_wvalid && (state == GRANT_WR) && !owner;
    assign m1_wvalid = mem_wvalid && (state == GRANT_WR) &&  owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            rr_ptr   <= 1'b0;
            owner    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // A pending write-back drains before a refill from the same master.
                    if (|req) begin
                        owner <= win;
                        state <= win_wen ? GRANT_WR : GRANT_RD;
                    end
                end
                GRANT_RD, GRANT_WR: begin
                    if (burst_done) begin
                        state    <= IDLE;
                        beat_cnt <= '0;
                        rr_ptr   <= ~owner;
                    end else if (beat_fire) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_PERF_EN
    logic held0;
    logic held1;

    assign held0 = (state != IDLE) && !owner;
    assign held1 = (state != IDLE) &&  owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_stall0 <= '0;
            perf_stall1 <= '0;
        end else begin
            if (burst_done && !owner) perf_grant0 <= perf_grant0 + 32'd1;
            if (burst_done &&  owner) perf_grant1 <= perf_grant1 + 32'd1;
            if (req[0] && !held0)     perf_stall0 <= perf_stall0 + 32'd1;
            if (req[1] && !held1)     perf_stall1 <= perf_stall1 + 32'd1;
        end
    end
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single 128-bit memory port between two cache masters: master 0 is the I-cache CMU and master 1 is the D-cache CMU. Each master performs cache-line refills (reads) and write-backs (writes) as bursts of BURST_BEATS 2-word beats. The arbiter grants one master and one direction at a time. It holds that grant for a whole burst, because the CMUs drop ren/wen between beats. It sits between the two Cache instances and the memory controller.

Parameters:
ADDR_WIDTH, 64, address width
DATA_WIDTH, 64, cache word width; memory beat is DATA_WIDTH*2
BURST_BEATS, 2, memory beats per cache line (BANK_NUM/2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
mN_ren  in  1  master N read request (N=0,1; all mN_* repeat per master)
mN_raddr  in  ADDR_WIDTH  read beat address
mN_rdata  out  DATA_WIDTH*2  read data (mem_rdata fanned out to both masters)
mN_rvalid  out  1  read beat done, only to the owner
mN_wen  in  1  write request
mN_waddr  in  ADDR_WIDTH  write beat address
mN_wdata  in  DATA_WIDTH*2  write data
mN_wmask  in  DATA_WIDTH*2/8  write byte mask
mN_wvalid  out  1  write beat done, only to the owner
mem_ren / mem_raddr / mem_wen / mem_waddr / mem_wdata / mem_wmask  out  as above  to memory
mem_rdata  in  DATA_WIDTH*2  memory read data
mem_rvalid, mem_wvalid  in  1  memory beat done
owner  out  1  current or last granted master, debug

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- States:
  - IDLE: no grant.
  - GRANT_RD: owner has the read channel.
  - GRANT_WR: owner has the write channel.
- Reset values:
  - state=IDLE, beat count=0, rr pointer=0, owner=0.
  - All mem_* outputs 0; all mN_rvalid and mN_wvalid 0.
- Reset mid-burst: abandons the burst immediately. The memory request is dropped the same edge.
- Arbitration in IDLE:
  - If exactly one master requests, that master wins.
  - If both request, the master pointed to by the rr pointer wins.
  - Within the winning master, wen beats ren. This lets a write-back drain before a new refill.
  - Grant registers on the next edge.
- Grant to memory latency: 1 cycle from request seen in IDLE.
- Datapath is combinational while granted:
  - mem_ren = owner mN_ren (GRANT_RD); mem_wen = owner mN_wen (GRANT_WR).
  - Address, data and mask are muxed from the owner.
  - The opposite-direction mem enable is forced to 0.
- mem_rvalid/mem_wvalid route only to the owner's matching valid. The other master's valids stay 0.
- Beat counter ($clog2(BURST_BEATS)+1 bits):
  - Increments on each valid in the granted direction.
  - On the valid that completes beat BURST_BEATS: go to IDLE, clear the counter, set rr pointer = ~owner.
  - IDLE re-arbitrates on the following cycle, giving 1 dead cycle between bursts.
- Owner deasserting its request between beats does not release the grant.
- A valid arriving in IDLE, or a valid in the wrong direction, is ignored and does not count.
- A new request from the non-owner during a burst waits; it is not lost, since requests are levels.

Optional Feature:
Macro ARB_PERF_EN.
- Defined:
  - Adds outputs perf_grant0, perf_grant1 (32 bits): bursts completed per master.
  - Adds perf_stall0, perf_stall1 (32 bits): cycles a master requested while not owner.
  - All four clear on rst and wrap on overflow.
- Undefined: these ports and their logic do not exist. Arbitration behaviour is identical either way.

Decomposition:
- Shared package mem_arb_pkg holds:
  - State enum arb_state_t (IDLE, GRANT_RD, GRANT_WR).
  - MEM_DATA_WIDTH = DATA_WIDTH*2 and MEM_MASK_WIDTH.
- One sub-module is natural: arb_rr2, a 2-requester round-robin picker (req[1:0] plus pointer in, grant index out, combinational).

Test Plan:
- Single read: m1_ren=1, m1_raddr=0x1000, memory returns rvalid at +3 and +7 cycles.
  - mem_raddr=0x1000 one cycle after the request.
  - m1_rvalid pulses twice, m0_rvalid stays 0.
  - IDLE after the 2nd beat.
- Contention: m0_ren and m1_ren rise the same cycle after reset (rr=0).
  - Master 0 is served first.
  - Master 1 is granted 2 cycles after master 0's last rvalid.
  - Then a new m0 request waits behind m1.
- Write priority: m1_wen and m1_ren both high.
  - GRANT_WR first; mem_wmask = 0xFFFF and mem_wdata are passed through.
  - mem_ren stays 0 until the write burst completes.
- Gap hold: m0 drops ren for 4 cycles between beats while m1_ren is held high.
  - Grant stays with m0; m1 is not granted until m0's 2nd rvalid.
- Reset mid-burst: assert rst after the 1st rvalid.
  - Next cycle all mem_* outputs are 0 and state is IDLE.
  - A stray mem_rvalid afterwards produces no mN_rvalid.
- With ARB_PERF_EN defined: contention scenario gives perf_grant0=1 and perf_grant1=1, and perf_stall1 equals the measured wait cycles.
